// File: rtl/drive_command_sequencer.sv
// Debounced pushbutton front end plus a SETUP/STROBE/HOLD sequencer that hands a
// latched drive command (or a speed clear) to the speed display.
module drive_command_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STROBE_CYCLES   = 4,
    parameter int HOLD_CYCLES     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_go_n,
    input  logic       key_clr_n,
    input  logic [1:0] sw_instruction,
    input  logic [1:0] sw_torque,
    input  logic       sw_enable,
    output logic [1:0] instruction,
    output logic [1:0] torque,
    output logic       enable,
    output logic       vel_clear,
    output logic       read_enable,
    output logic       busy,
    output logic [7:0] cmd_count
);

    localparam int DBW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PMAX = (STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

    localparam logic [DBW-1:0] DB_LAST     = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0]  STROBE_LAST = PW'(STROBE_CYCLES - 1);
    localparam logic [PW-1:0]  HOLD_LAST   = PW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RELEASE
    } state_t;

    // Key index 0 is the go key, index 1 the clear key.
    logic [1:0]     sync_p0;
    logic [1:0]     sync_p1;
    logic [1:0]     db_level;
    logic [1:0]     db_level_d;
    logic [DBW-1:0] db_cnt [2];

    state_t         state;
    state_t         state_nxt;
    logic [PW-1:0]  phase_cnt;
    logic           boot_clr;
    logic           from_boot;
    logic           start;
    logic           start_clr;
    logic           go_press;
    logic           clr_press;

    // Stage p0/p1: two-flop synchroniser, then a debouncer that only moves the
    // accepted level after DEBOUNCE_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0    <= 2'b11;
            sync_p1    <= 2'b11;
            db_level   <= 2'b11;
            db_level_d <= 2'b11;
            for (int k = 0; k < 2; k++) begin
                db_cnt[k] <= '0;
            end
        end else begin
            sync_p0    <= {key_clr_n, key_go_n};
            sync_p1    <= sync_p0;
            db_level_d <= db_level;
            for (int k = 0; k < 2; k++) begin
                if (sync_p1[k] == db_level[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_LAST) begin
                    db_level[k] <= sync_p1[k];
                    db_cnt[k]   <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + DBW'(1);
                end
            end
        end
    end

    assign go_press  = db_level_d[0] & ~db_level[0];
    assign clr_press = db_level_d[1] & ~db_level[1];
    assign busy      = (state != IDLE);

    // Sequencer: a pending post-reset clear outranks keys, and clear outranks go.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        start_clr = 1'b0;
        case (state)
            IDLE: begin
                if (boot_clr || clr_press) begin
                    state_nxt = SETUP;
                    start     = 1'b1;
                    start_clr = 1'b1;
                end else if (go_press) begin
                    state_nxt = SETUP;
                    start     = 1'b1;
                end
            end
            SETUP:   state_nxt = STROBE;
            STROBE:  if (phase_cnt == STROBE_LAST) state_nxt = HOLD;
            HOLD:    if (phase_cnt == HOLD_LAST) state_nxt = from_boot ? IDLE : RELEASE;
            RELEASE: if (vel_clear ? db_level[1] : db_level[0]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            boot_clr    <= 1'b1;
            from_boot   <= 1'b0;
            instruction <= 2'b00;
            torque      <= 2'b00;
            enable      <= 1'b0;
            vel_clear   <= 1'b0;
            read_enable <= 1'b0;
            cmd_count   <= 8'd0;
        end else begin
            state       <= state_nxt;
            read_enable <= (state_nxt == STROBE);
            if (state_nxt != state) begin
                phase_cnt <= '0;
            end else if (state == STROBE || state == HOLD) begin
                phase_cnt <= phase_cnt + PW'(1);
            end
            if (state == IDLE) begin
                enable <= sw_enable;
            end
            if (start) begin
                instruction <= sw_instruction;
                torque      <= sw_torque;
                vel_clear   <= start_clr;
                from_boot   <= boot_clr;
                boot_clr    <= 1'b0;
            end
            if (state == SETUP && !vel_clear) begin
                cmd_count <= cmd_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_drive_command_sequencer.sv
// Directed and randomized bench for drive_command_sequencer against a
// timeline-based reference model of the debounce and command sequence.
module tb_drive_command_sequencer;

    localparam int DB = 4;
    localparam int S  = 2;
    localparam int H  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_go_n;
    logic       key_clr_n;
    logic [1:0] sw_instruction;
    logic [1:0] sw_torque;
    logic       sw_enable;
    logic [1:0] instruction;
    logic [1:0] torque;
    logic       enable;
    logic       vel_clear;
    logic       read_enable;
    logic       busy;
    logic [7:0] cmd_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    drive_command_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .STROBE_CYCLES  (S),
        .HOLD_CYCLES    (H)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_go_n      (key_go_n),
        .key_clr_n     (key_clr_n),
        .sw_instruction(sw_instruction),
        .sw_torque     (sw_torque),
        .sw_enable     (sw_enable),
        .instruction   (instruction),
        .torque        (torque),
        .enable        (enable),
        .vel_clear     (vel_clear),
        .read_enable   (read_enable),
        .busy          (busy),
        .cmd_count     (cmd_count)
    );

    // Reference model: a sequence is a timeline t = 0 (setup), 1..S (strobe),
    // S+1..S+H (hold), S+H+1 (waiting for the originating key to be released).
    bit          m_active;
    bit          m_boot;
    bit          m_from_boot;
    bit          m_vc;
    bit          m_en;
    int          m_t;
    logic [1:0]  m_instr;
    logic [1:0]  m_torq;
    logic [7:0]  m_cnt;
    logic [1:0]  m_s1;
    logic [1:0]  m_s2;
    logic [1:0]  m_db;
    logic [1:0]  m_dbp;
    logic [DB-1:0] m_hist [2];

    int   rises;
    logic re_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic go_p;
        logic clr_p;
        if (reset) begin
            m_active    = 1'b0;
            m_boot      = 1'b1;
            m_from_boot = 1'b0;
            m_vc        = 1'b0;
            m_en        = 1'b0;
            m_t         = 0;
            m_instr     = 2'b00;
            m_torq      = 2'b00;
            m_cnt       = 8'd0;
            m_s1        = 2'b11;
            m_s2        = 2'b11;
            m_db        = 2'b11;
            m_dbp       = 2'b11;
            m_hist[0]   = '1;
            m_hist[1]   = '1;
        end else begin
            go_p  = m_dbp[0] & ~m_db[0];
            clr_p = m_dbp[1] & ~m_db[1];
            if (!m_active) begin
                m_en = sw_enable;
                if (m_boot || clr_p || go_p) begin
                    m_active    = 1'b1;
                    m_t         = 0;
                    m_instr     = sw_instruction;
                    m_torq      = sw_torque;
                    m_vc        = m_boot || clr_p;
                    m_from_boot = m_boot;
                    m_boot      = 1'b0;
                end
            end else if (m_t == S + H + 1) begin
                if (m_vc ? m_db[1] : m_db[0]) m_active = 1'b0;
            end else begin
                m_t++;
                if (m_t == 1 && !m_vc) m_cnt = m_cnt + 8'd1;
                if (m_t == S + H + 1 && m_from_boot) m_active = 1'b0;
            end
            // A key level is accepted once the last DB synchronised samples agree.
            m_dbp = m_db;
            for (int k = 0; k < 2; k++) begin
                m_hist[k] = {m_hist[k][DB-2:0], m_s2[k]};
                if (m_hist[k] == '1) m_db[k] = 1'b1;
                else if (m_hist[k] == '0) m_db[k] = 1'b0;
            end
            m_s2 = m_s1;
            m_s1 = {key_clr_n, key_go_n};
        end
    endtask

    task automatic tick();
        bit exp_re;
        @(posedge clk);
        model_step();
        #1;
        if (read_enable === 1'b1 && re_last !== 1'b1) rises++;
        re_last = read_enable;
        exp_re = m_active && (m_t >= 1) && (m_t <= S);
        chk("read_enable", 32'(read_enable), 32'(exp_re));
        chk("busy",        32'(busy),        32'(m_active));
        chk("instruction", 32'(instruction), 32'(m_instr));
        chk("torque",      32'(torque),      32'(m_torq));
        chk("enable",      32'(enable),      32'(m_en));
        chk("vel_clear",   32'(vel_clear),   32'(m_vc));
        chk("cmd_count",   32'(cmd_count),   32'(m_cnt));
    endtask

    task automatic wait_re(input string tag);
        int n;
        n = 0;
        while (read_enable !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(read_enable), 32'd1);
    endtask

    initial begin
        int first_hi;
        int hi_cnt;
        int r0;
        logic [7:0] c0;

        reset          = 1'b1;
        key_go_n       = 1'b1;
        key_clr_n      = 1'b1;
        sw_instruction = 2'b00;
        sw_torque      = 2'b00;
        sw_enable      = 1'b0;
        re_last        = 1'b0;
        rises          = 0;

        repeat (3) tick();
        chk("rst_busy",        32'(busy),        32'd0);
        chk("rst_read_enable", 32'(read_enable), 32'd0);
        chk("rst_cmd_count",   32'(cmd_count),   32'd0);
        chk("rst_vel_clear",   32'(vel_clear),   32'd0);

        // Post-reset clear sequence
        reset     = 1'b0;
        sw_enable = 1'b1;
        first_hi  = -1;
        hi_cnt    = 0;
        tick();
        chk("boot_setup_vel_clear", 32'(vel_clear), 32'd1);
        chk("boot_setup_busy",      32'(busy),      32'd1);
        if (read_enable === 1'b1) begin
            hi_cnt++;
            first_hi = 1;
        end
        for (int i = 2; i <= 8; i++) begin
            tick();
            if (read_enable === 1'b1) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = i;
            end
        end
        chk("boot_first_hi",  32'(first_hi),  32'd2);
        chk("boot_hi_cycles", 32'(hi_cnt),    32'd2);
        chk("boot_busy_end",  32'(busy),      32'd0);
        chk("boot_cmd_count", 32'(cmd_count), 32'd0);

        // Long go press: one strobe only
        sw_instruction = 2'b00;
        sw_torque      = 2'b11;
        r0             = rises;
        key_go_n       = 1'b0;
        repeat (20) tick();
        key_go_n = 1'b1;
        repeat (10) tick();
        chk("go_hold_strobes", 32'(rises - r0), 32'd1);
        chk("go_instruction",  32'(instruction), 32'd0);
        chk("go_torque",       32'(torque),      32'd3);
        chk("go_cmd_count",    32'(cmd_count),   32'd1);
        key_go_n = 1'b0;
        repeat (12) tick();
        key_go_n = 1'b1;
        repeat (10) tick();
        chk("repress_strobes", 32'(rises - r0), 32'd2);
        chk("repress_count",   32'(cmd_count),  32'd2);

        // Bouncing go key
        r0 = rises;
        for (int i = 0; i < 8; i++) begin
            key_go_n = i[0];
            repeat (2) tick();
        end
        chk("bounce_no_strobe", 32'(rises - r0), 32'd0);
        key_go_n = 1'b0;
        repeat (14) tick();
        key_go_n = 1'b1;
        repeat (10) tick();
        chk("bounce_one_strobe", 32'(rises - r0), 32'd1);
        chk("bounce_count",      32'(cmd_count),  32'd3);

        // Torque change during strobe is ignored
        sw_torque = 2'b01;
        key_go_n  = 1'b0;
        wait_re("torque_wait_strobe");
        sw_torque = 2'b10;
        repeat (3) tick();
        chk("torque_frozen", 32'(torque), 32'd1);
        key_go_n = 1'b1;
        repeat (10) tick();
        key_go_n = 1'b0;
        repeat (12) tick();
        key_go_n = 1'b1;
        repeat (10) tick();
        chk("torque_second", 32'(torque), 32'd2);

        // Both keys in the same cycle: clear wins
        c0        = cmd_count;
        r0        = rises;
        key_go_n  = 1'b0;
        key_clr_n = 1'b0;
        repeat (12) tick();
        chk("both_vel_clear", 32'(vel_clear), 32'd1);
        key_go_n  = 1'b1;
        key_clr_n = 1'b1;
        repeat (10) tick();
        chk("both_strobes", 32'(rises - r0), 32'd1);
        chk("both_count",   32'(cmd_count),  32'(c0));

        // Randomized keys and switches
        for (int seg = 0; seg < 80; seg++) begin
            key_go_n       = 1'($urandom_range(0, 1));
            key_clr_n      = 1'($urandom_range(0, 1));
            sw_instruction = 2'($urandom_range(0, 3));
            sw_torque      = 2'($urandom_range(0, 3));
            sw_enable      = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 10)) tick();
        end
        key_go_n  = 1'b1;
        key_clr_n = 1'b1;
        repeat (12) tick();

        // 256 go presses from reset wrap the counter
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (8) tick();
        r0 = rises;
        for (int p = 0; p < 256; p++) begin
            key_go_n = 1'b0;
            repeat (12) tick();
            key_go_n = 1'b1;
            repeat (10) tick();
        end
        chk("wrap_strobes", 32'(rises - r0), 32'd256);
        chk("wrap_count",   32'(cmd_count),  32'd0);

        // Reset in the middle of a strobe
        key_go_n = 1'b0;
        wait_re("rst_wait_strobe");
        reset = 1'b1;
        tick();
        chk("rst_mid_read_enable", 32'(read_enable), 32'd0);
        chk("rst_mid_cmd_count",   32'(cmd_count),   32'd0);
        reset    = 1'b0;
        key_go_n = 1'b1;
        repeat (12) tick();
        chk("rst_mid_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
